vic20_prg_loader: RTL and testbench
===================================

// Module: vic20_prg_loader
// PURPOSE
// - Sits between the data_io download stream and the SDRAM/internal-memory write port of the VIC-20 top level.
// - Turns a PRG/CRT byte stream into addressed memory writes.
// - After the load it patches the BASIC pointers and, for cartridges at $A000, requests a CPU reset.
// - ROM downloads (index 0) are ignored; the top level routes them elsewhere.
// PARAMETERS
// - RESET_HOLD   16   cycles cpu_reset_req stays high after a cartridge load (>=1)
// - CART_BASE    16'hA000  load address for headerless CRT; also the auto-reset trigger address
// PORTS
// - clk_sys        in   1   system clock; single clock domain
// - reset          in   1   synchronous, active-high
// - ioctl_download in   1   download active
// - ioctl_index    in   8   download type; 0 = ROM (ignored), [4:0]==1 = PRG
// - ioctl_wr       in   1   one-cycle strobe: ioctl_addr/ioctl_dout valid
// - ioctl_addr     in   16  byte offset within file
// - ioctl_dout     in   8   file byte
// - hdr_en         in   1   1 = non-PRG files also carry a 2-byte load address
// - mem_req        out  1   write request; addr/data stable while high
// - mem_ack        in   1   write accepted this cycle
// - mem_addr       out  16  target address
// - mem_data       out  8   write data
// - mem_internal   out  1   mem_addr decodes to internal BRAM: $0000-$03FF, $1000-$1FFF, $9400-$97FF
// - busy           out  1   loader owns memory; top level gates the CPU clock enable
// - cpu_reset_req  out  1   auto-reset request
// - overrun        out  1   sticky: a byte was lost
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; buffer empty; overrun cleared.
// - Header decision at download start: hdr = (ioctl_index[4:0]==1) | hdr_en.
//   - hdr: offsets 0/1 load load_addr lo/hi and generate no write; offset n>=2 writes to load_addr + n - 2.
//   - no hdr: offset n writes to CART_BASE + n.
//   - All address arithmetic is 16-bit and wraps $FFFF->$0000.
// - States: IDLE -> LOAD (ioctl_download rises with index!=0; busy=1) -> DRAIN (download falls) -> INJECT -> (RST | IDLE).
// - Handshake:
//   - mem_req rises the cycle after a byte is accepted.
//   - The write completes on the first cycle with mem_req & mem_ack; mem_req is low the following cycle unless the buffer is non-empty.
//   - mem_ack without mem_req is ignored.
// - Buffering: 1-entry holding register behind the output register.
//   - A byte arriving with both full is dropped and sets overrun.
//   - Simultaneous ack and new byte: the buffer advances and the byte is accepted, no loss.
// - end_ptr = last written address + 1, tracked in LOAD.
// - DRAIN waits until the output register and buffer are both empty.
// - INJECT issues 8 writes through the same handshake, in order:
//   - $2D/$2E = end_ptr lo/hi, $2F/$30 = end_ptr, $31/$32 = end_ptr, $AE/$AF = end_ptr.
//   - Skipped, straight to IDLE, if no data byte was written (empty file or header-only).
// - Auto-reset: cart_flag sets when any write targets CART_BASE during LOAD.
//   - After INJECT with cart_flag, RST holds cpu_reset_req for RESET_HOLD cycles, then returns to IDLE and clears cart_flag.
// - busy is high from LOAD entry until return to IDLE.
// - ioctl_wr outside LOAD is ignored. A new download rising during DRAIN/INJECT/RST is not started; its bytes count as overrun.
// - reset mid-operation aborts immediately: in-flight and pending writes are discarded, nothing is injected, cpu_reset_req drops the same cycle.
// STRUCTURE
// - Shared package vic20_pkg: state enum loader_state_t; localparams for the injection address table, the internal-memory decode ranges, and PRG_INDEX=5'd1.
// - One sub-module, vic20_wr_skid: 2-entry addr/data skid buffer with req/ack output and overflow flag; reused for LOAD and INJECT writes.
// - Everything else (header capture, end_ptr, state machine, reset counter) stays in this module.
// TESTING
// - PRG 01 10 AA BB CC, index 1, ack always high -> writes $1001=AA, $1002=BB, $1003=CC; injects end_ptr $1004 at $2D..$32,$AE,$AF; cpu_reset_req stays 0.
// - 4 KB CRT, index 2, hdr_en=0 -> writes $A000..$AFFF; injected end_ptr $B000; cpu_reset_req high exactly RESET_HOLD cycles after the last inject ack.
// - mem_ack low for 10 cycles, 3 back-to-back bytes -> first two held (addr/data stable), third dropped; overrun=1; other writes correct after ack.
// - Header-only PRG (2 bytes) -> no mem_req at all; busy returns to 0 after download ends.
// - Assert reset during INJECT write 4 -> mem_req, busy, cpu_reset_req all 0 next cycle; no further writes.
// - Load address $FFFF, 3 data bytes -> writes $FFFF, $0000, $0001; end_ptr $0002; mem_internal=1 for $0000/$0001.

Source files
------------

// File: rtl/vic20_pkg.sv
// Shared types and constants for the VIC-20 PRG/CRT loader.
package vic20_pkg;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_INJECT,
    ST_RST
  } loader_state_t;

  // ioctl_index[4:0] value that marks a PRG file (always carries a load address).
  localparam logic [4:0] PRG_INDEX = 5'd1;

  // BASIC pointer patch: eight byte writes, even entries take end_ptr lo, odd take hi.
  localparam int INJ_COUNT = 8;
  localparam logic [INJ_COUNT-1:0][15:0] INJ_ADDR = {
    16'h00AF, 16'h00AE, 16'h0032, 16'h0031,
    16'h0030, 16'h002F, 16'h002E, 16'h002D
  };

  // Address windows served by internal block RAM instead of SDRAM.
  localparam int INT_RANGES = 3;
  localparam logic [INT_RANGES-1:0][15:0] INT_FIRST = {16'h9400, 16'h1000, 16'h0000};
  localparam logic [INT_RANGES-1:0][15:0] INT_LAST  = {16'h97FF, 16'h1FFF, 16'h03FF};

endpackage

// File: rtl/vic20_wr_skid.sv
// Two-entry write skid: an output register presenting mem_req/addr/data and a
// single holding register behind it. A push that finds both occupied (and no
// ack freeing a slot this cycle) is dropped and reported on drop.
module vic20_wr_skid (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        push,
  input  logic [15:0] push_addr,
  input  logic [7:0]  push_data,
  output logic        drop,
  output logic        full,
  output logic        empty,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data
);

  logic        out_valid_reg, out_valid_next;
  logic [15:0] out_addr_reg,  out_addr_next;
  logic [7:0]  out_data_reg,  out_data_next;
  logic        buf_valid_reg, buf_valid_next;
  logic [15:0] buf_addr_reg,  buf_addr_next;
  logic [7:0]  buf_data_reg,  buf_data_next;
  logic        fire;

  // An ack only counts while a request is actually presented.
  assign fire  = out_valid_reg & mem_ack;
  assign drop  = push & out_valid_reg & buf_valid_reg & ~mem_ack;
  assign full  = buf_valid_reg;
  assign empty = ~out_valid_reg & ~buf_valid_reg;

  assign mem_req  = out_valid_reg;
  assign mem_addr = out_addr_reg;
  assign mem_data = out_data_reg;

  // Retire the acked entry first, then place a new byte in the first free slot.
  always_comb begin
    out_valid_next = out_valid_reg;
    out_addr_next  = out_addr_reg;
    out_data_next  = out_data_reg;
    buf_valid_next = buf_valid_reg;
    buf_addr_next  = buf_addr_reg;
    buf_data_next  = buf_data_reg;
    if (fire) begin
      if (buf_valid_reg) begin
        out_addr_next  = buf_addr_reg;
        out_data_next  = buf_data_reg;
        buf_valid_next = 1'b0;
      end else begin
        out_valid_next = 1'b0;
      end
    end
    if (push && !drop) begin
      if (!out_valid_next) begin
        out_valid_next = 1'b1;
        out_addr_next  = push_addr;
        out_data_next  = push_data;
      end else begin
        buf_valid_next = 1'b1;
        buf_addr_next  = push_addr;
        buf_data_next  = push_data;
      end
    end
  end

  // Register both slots; reset discards anything in flight.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_addr_reg  <= '0;
      out_data_reg  <= '0;
      buf_valid_reg <= 1'b0;
      buf_addr_reg  <= '0;
      buf_data_reg  <= '0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_addr_reg  <= out_addr_next;
      out_data_reg  <= out_data_next;
      buf_valid_reg <= buf_valid_next;
      buf_addr_reg  <= buf_addr_next;
      buf_data_reg  <= buf_data_next;
    end
  end

endmodule

// File: rtl/vic20_prg_loader.sv
// Converts a PRG/CRT download stream into addressed memory writes, patches the
// BASIC end pointers afterwards and requests a CPU reset for $A000 cartridges.
module vic20_prg_loader
  import vic20_pkg::*;
#(
  parameter int          RESET_HOLD = 16,
  parameter logic [15:0] CART_BASE  = 16'hA000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [15:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        hdr_en,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_internal,
  output logic        busy,
  output logic        cpu_reset_req,
  output logic        overrun
);

  loader_state_t state_reg, state_next;

  logic        dl_prev_reg;
  logic        hdr_reg;
  logic [15:0] load_addr_reg;
  logic [15:0] end_ptr_reg;
  logic        data_written_reg;
  logic        cart_flag_reg;
  logic [3:0]  inj_idx_reg;
  logic [15:0] rst_cnt_reg;
  logic        ignore_dl_reg;
  logic        overrun_reg;

  logic        dl_rise, start_load, load_wr, hdr_byte, data_push, accepted;
  logic        inj_done, inj_push, skid_push, skid_drop, skid_full, skid_empty;
  logic        rst_done;
  logic [15:0] data_addr, skid_addr_in;
  logic [7:0]  skid_data_in;
  logic [INT_RANGES-1:0] int_hit;

  assign dl_rise    = ioctl_download & ~dl_prev_reg;
  assign start_load = (state_reg == ST_IDLE) && dl_rise && (ioctl_index != 8'd0);

  // File offsets 0/1 are the load address when a header is present.
  assign load_wr   = (state_reg == ST_LOAD) && ioctl_wr;
  assign hdr_byte  = hdr_reg && (ioctl_addr < 16'd2);
  assign data_addr = hdr_reg ? (load_addr_reg + ioctl_addr - 16'd2) : (CART_BASE + ioctl_addr);
  assign data_push = load_wr && !hdr_byte;
  assign accepted  = data_push && !skid_drop;

  // Injection pushes one entry at a time and only when the holding slot is free.
  assign inj_done = (inj_idx_reg == 4'(INJ_COUNT));
  assign inj_push = (state_reg == ST_INJECT) && !inj_done && !skid_full;
  assign rst_done = (rst_cnt_reg == 16'(RESET_HOLD - 1));

  assign skid_push    = data_push | inj_push;
  assign skid_addr_in = inj_push ? INJ_ADDR[inj_idx_reg[2:0]] : data_addr;
  assign skid_data_in = inj_push ? (inj_idx_reg[0] ? end_ptr_reg[15:8] : end_ptr_reg[7:0])
                                 : ioctl_dout;

  vic20_wr_skid u_skid (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .push      (skid_push),
    .push_addr (skid_addr_in),
    .push_data (skid_data_in),
    .drop      (skid_drop),
    .full      (skid_full),
    .empty     (skid_empty),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data)
  );

  // Internal-memory decode; offset compare avoids a degenerate >= 0 test.
  for (genvar gi = 0; gi < INT_RANGES; gi++) begin : g_int_hit
    assign int_hit[gi] = (16'(mem_addr - INT_FIRST[gi]) <= 16'(INT_LAST[gi] - INT_FIRST[gi]));
  end
  assign mem_internal = mem_req & (|int_hit);
  assign overrun      = overrun_reg;

  // State register.
  always_ff @(posedge clk_sys) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE:   if (start_load) state_next = ST_LOAD;
      ST_LOAD:   if (!ioctl_download) state_next = ST_DRAIN;
      ST_DRAIN:  if (skid_empty) state_next = data_written_reg ? ST_INJECT : ST_IDLE;
      ST_INJECT: if (inj_done && skid_empty) state_next = cart_flag_reg ? ST_RST : ST_IDLE;
      ST_RST:    if (rst_done) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs; reset request drops in the same cycle reset is seen.
  always_comb begin
    busy          = (state_reg != ST_IDLE);
    cpu_reset_req = (state_reg == ST_RST) && !reset;
  end

  // Header capture, end pointer, flags and counters.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_prev_reg      <= 1'b0;
      hdr_reg          <= 1'b0;
      load_addr_reg    <= '0;
      end_ptr_reg      <= '0;
      data_written_reg <= 1'b0;
      cart_flag_reg    <= 1'b0;
      inj_idx_reg      <= '0;
      rst_cnt_reg      <= '0;
      ignore_dl_reg    <= 1'b0;
      overrun_reg      <= 1'b0;
    end else begin
      dl_prev_reg <= ioctl_download;

      if (start_load) begin
        hdr_reg          <= (ioctl_index[4:0] == PRG_INDEX) | hdr_en;
        load_addr_reg    <= '0;
        end_ptr_reg      <= '0;
        data_written_reg <= 1'b0;
        cart_flag_reg    <= 1'b0;
      end

      if (load_wr && hdr_byte) begin
        if (ioctl_addr[0]) load_addr_reg[15:8] <= ioctl_dout;
        else               load_addr_reg[7:0]  <= ioctl_dout;
      end

      if (accepted) begin
        end_ptr_reg      <= data_addr + 16'd1;
        data_written_reg <= 1'b1;
        if (data_addr == CART_BASE) cart_flag_reg <= 1'b1;
      end

      if (state_reg != ST_INJECT) inj_idx_reg <= '0;
      else if (inj_push)          inj_idx_reg <= inj_idx_reg + 4'd1;

      if (state_reg == ST_RST) rst_cnt_reg <= rst_cnt_reg + 16'd1;
      else                     rst_cnt_reg <= '0;

      if ((state_reg == ST_RST) && rst_done) cart_flag_reg <= 1'b0;

      // A download that rises while the loader is still finishing is never started.
      if (!ioctl_download)
        ignore_dl_reg <= 1'b0;
      else if (dl_rise && (state_reg == ST_DRAIN || state_reg == ST_INJECT || state_reg == ST_RST))
        ignore_dl_reg <= 1'b1;

      if (skid_drop || (ignore_dl_reg && ioctl_wr)) overrun_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vic20_prg_loader.sv
// Scoreboard bench for vic20_prg_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares every accepted memory write.
module tb_vic20_prg_loader;

  localparam int          RESET_HOLD = 16;
  localparam logic [15:0] CART_BASE  = 16'hA000;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = '0;
  logic        ioctl_wr = 1'b0;
  logic [15:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        hdr_en = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_internal, busy, cpu_reset_req, overrun;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;

  vic20_prg_loader #(.RESET_HOLD(RESET_HOLD), .CART_BASE(CART_BASE)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .hdr_en         (hdr_en),
    .mem_req        (mem_req),
    .mem_ack        (mem_ack),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_internal   (mem_internal),
    .busy           (busy),
    .cpu_reset_req  (cpu_reset_req),
    .overrun        (overrun)
  );

  always #5 clk_sys = ~clk_sys;

  wr_t         exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          rst_cycles = 0;
  int          req_cycles = 0;
  int          rise_cyc = 0;
  int          last_ack_cyc = 0;
  bit          prev_req = 0, prev_ack = 0, prev_rst = 0;
  logic [15:0] prev_addr = '0;
  logic [7:0]  prev_data = '0;
  bit          ack_rand = 0, ack_force = 1, stall_en = 0;
  logic [15:0] stall_addr = 16'h0030;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout, expected event", name);
  endtask

  function automatic bit is_internal(input logic [15:0] a);
    return (a < 16'h0400) || (a >= 16'h1000 && a < 16'h2000) || (a >= 16'h9400 && a < 16'h9800);
  endfunction

  initial forever begin
    @(posedge clk_sys);
    cyc++;
  end

  // Memory responder: ack always, randomly, or stalled on one address.
  initial forever begin
    @(posedge clk_sys);
    #1;
    mem_ack = (ack_rand ? ($urandom_range(0, 3) != 0) : ack_force)
              & ~(stall_en & mem_req & (mem_addr == stall_addr));
  end

  // Monitor: hold-stability, write scoreboard, reset-request timing.
  initial forever begin
    wr_t e;
    @(negedge clk_sys);
    if (reset) begin
      prev_req = 0; prev_ack = 0; prev_rst = 0;
    end else begin
      if (prev_req && !prev_ack) begin
        check("hold_req", mem_req, 1);
        if (mem_req) begin
          check("hold_addr", mem_addr, prev_addr);
          check("hold_data", mem_data, prev_data);
        end
      end
      if (mem_req) req_cycles++;
      if (mem_req && mem_ack) begin
        last_ack_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr %04h data %02h, expected no write", mem_addr, mem_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", mem_addr, e.a);
          check("wr_data", mem_data, e.d);
          check("mem_internal", mem_internal, is_internal(e.a));
        end
      end
      if (cpu_reset_req) begin
        rst_cycles++;
        if (!prev_rst) rise_cyc = cyc;
      end
      prev_req  = mem_req;
      prev_ack  = mem_ack;
      prev_rst  = cpu_reset_req;
      prev_addr = mem_addr;
      prev_data = mem_data;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic put_byte(input int off, input logic [7:0] d);
    ioctl_wr = 1'b1;
    ioctl_addr = 16'(off);
    ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
  endtask

  // Keep at most one write outstanding before offering another byte.
  task automatic wait_room();
    int t = 0;
    while (exp_q.size() > 1 && t < 2000) begin tick(); t++; end
    if (t >= 2000) fail("pace_timeout");
  endtask

  task automatic start_test();
    rst_cycles = 0; req_cycles = 0; rise_cyc = 0; last_ack_cyc = 0;
  endtask

  task automatic push_inject(input logic [15:0] endp, input int count);
    logic [15:0] ia [8];
    ia = '{16'h002D, 16'h002E, 16'h002F, 16'h0030, 16'h0031, 16'h0032, 16'h00AE, 16'h00AF};
    for (int i = 0; i < count; i++)
      exp_q.push_back(wr_t'{ia[i], (i % 2 == 0) ? endp[7:0] : endp[15:8]});
  endtask

  // Reference model: header rule and address wrap from plain arithmetic.
  task automatic load_file(input logic [7:0] idx, input bit hen, input logic [7:0] bytes[$],
                           output bit any, output logic [15:0] endp, output bit cart, output int nw);
    bit hdr;
    logic [15:0] base, a;
    hdr = (idx[4:0] == 5'd1) || hen;
    any = 0; cart = 0; endp = '0; nw = 0;
    base = (bytes.size() >= 2) ? {bytes[1], bytes[0]} : 16'h0000;
    hdr_en = hen; ioctl_index = idx; ioctl_download = 1'b1;
    tick();
    for (int n = 0; n < bytes.size(); n++) begin
      if (idx != 8'd0 && !(hdr && n < 2)) begin
        a = hdr ? 16'(base + 16'(n) - 16'd2) : 16'(CART_BASE + 16'(n));
        wait_room();
        exp_q.push_back(wr_t'{a, bytes[n]});
        any = 1; endp = 16'(a + 16'd1); nw++;
        if (a == CART_BASE) cart = 1;
      end
      put_byte(n, bytes[n]);
      repeat ($urandom_range(0, 2)) tick();
    end
    ioctl_download = 1'b0;
  endtask

  task automatic finish_test(input int exp_rst, input bit exp_ovr);
    int t = 0;
    tick(); tick();
    while ((busy || exp_q.size() != 0) && t < 3000) begin tick(); t++; end
    if (t >= 3000) fail("idle_timeout");
    repeat (4) tick();
    check("queue_empty", exp_q.size(), 0);
    check("busy_idle", busy, 0);
    check("rst_cycles", rst_cycles, exp_rst);
    check("overrun", overrun, exp_ovr);
    if (exp_rst != 0)
      check("rst_latency", ((rise_cyc - last_ack_cyc) >= 1) && ((rise_cyc - last_ack_cyc) <= 3), 1);
  endtask

  task automatic run_file(input string tag, input logic [7:0] idx, input bit hen, input logic [7:0] bytes[$]);
    bit any, cart;
    logic [15:0] endp;
    int nw;
    start_test();
    load_file(idx, hen, bytes, any, endp, cart, nw);
    if (any) push_inject(endp, 8);
    finish_test(cart ? RESET_HOLD : 0, 0);
    $display("%s: idx=%0d hdr_en=%0b len=%0d writes=%0d end_ptr=%04h cart=%0b",
             tag, idx, hen, bytes.size(), nw, endp, cart);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] b[$];
    logic [7:0] d0, d1, d2, d3, ridx;
    bit any, cart, found;
    logic [15:0] endp;
    int nw, t;

    // Reset state.
    repeat (3) tick();
    @(negedge clk_sys);
    check("rst_mem_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_cpu_reset_req", cpu_reset_req, 0);
    check("rst_overrun", overrun, 0);
    check("rst_mem_internal", mem_internal, 0);
    tick();
    reset = 1'b0;
    tick();

    // Basic PRG with ack always high.
    ack_force = 1; ack_rand = 0;
    b = '{8'h01, 8'h10, 8'hAA, 8'hBB, 8'hCC};
    run_file("prg_basic", 8'd1, 1'b0, b);

    // 4 KB headerless cartridge with random ack.
    ack_rand = 1;
    b = {};
    for (int i = 0; i < 4096; i++) b.push_back(8'($urandom));
    run_file("crt_4k", 8'd2, 1'b0, b);

    // Header-only PRG: no memory traffic at all.
    ack_rand = 0;
    b = '{8'h01, 8'h10};
    run_file("hdr_only", 8'd1, 1'b0, b);
    check("hdr_only_no_req", req_cycles, 0);

    // Load address wrap at $FFFF.
    ack_rand = 1;
    b = '{8'hFF, 8'hFF, 8'h11, 8'h22, 8'h33};
    run_file("wrap", 8'd1, 1'b0, b);

    // Overrun: ack low, three back-to-back data bytes, third is lost.
    start_test();
    ack_rand = 0; ack_force = 0;
    d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom); d3 = 8'($urandom);
    hdr_en = 0; ioctl_index = 8'd1; ioctl_download = 1'b1;
    tick();
    put_byte(0, 8'h00);
    put_byte(1, 8'h20);
    exp_q.push_back(wr_t'{16'h2000, d0});
    exp_q.push_back(wr_t'{16'h2001, d1});
    put_byte(2, d0);
    put_byte(3, d1);
    put_byte(4, d2);
    repeat (10) tick();
    @(negedge clk_sys);
    check("stall_req", mem_req, 1);
    check("stall_addr", mem_addr, 16'h2000);
    check("stall_data", mem_data, d0);
    check("stall_overrun", overrun, 1);
    tick();
    ack_force = 1;
    wait_room();
    exp_q.push_back(wr_t'{16'h2003, d3});
    put_byte(5, d3);
    ioctl_download = 1'b0;
    push_inject(16'h2004, 8);
    finish_test(0, 1);
    $display("overrun: idx=1 writes=3 dropped=1 end_ptr=2004");
    do_reset();
    @(negedge clk_sys);
    check("overrun_cleared", overrun, 0);
    tick();

    // Reset while the fourth injection write is stalled.
    start_test();
    stall_en = 1; ack_force = 1; ack_rand = 0;
    b = '{8'h00, 8'h30, 8'($urandom), 8'($urandom)};
    load_file(8'd1, 1'b0, b, any, endp, cart, nw);
    push_inject(endp, 3);
    found = 0; t = 0;
    while (!found && t < 500) begin
      @(negedge clk_sys);
      if (mem_req && mem_addr == 16'h0030) found = 1;
      t++;
    end
    if (!found) fail("inject4_timeout");
    tick();
    reset = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    check("abort_mem_req", mem_req, 0);
    check("abort_busy", busy, 0);
    check("abort_cpu_reset_req", cpu_reset_req, 0);
    tick();
    reset = 1'b0;
    stall_en = 0;
    req_cycles = 0;
    repeat (30) tick();
    check("abort_no_writes", req_cycles, 0);
    check("abort_queue", exp_q.size(), 0);
    check("abort_idle", busy, 0);
    $display("reset_abort: end_ptr=%04h injected=3", endp);

    // Randomized files across indices, header modes and lengths.
    for (int k = 0; k < 10; k++) begin
      case ($urandom_range(0, 4))
        0: ridx = 8'd0;
        1: ridx = 8'd1;
        2: ridx = 8'd2;
        3: ridx = 8'd33;
        default: ridx = 8'd7;
      endcase
      b = {};
      nw = $urandom_range(0, 24);
      for (int i = 0; i < nw; i++) b.push_back(8'($urandom));
      if (nw >= 2 && $urandom_range(0, 2) == 0) begin
        b[0] = 8'h00;
        b[1] = 8'hA0;
      end
      ack_rand = 1;
      run_file("random", ridx, 1'($urandom_range(0, 1)), b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
